uart_framer: RTL

UART_FRAMER -- requirements
Module: uart_framer

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_fwft_fifo.sv | 54 +++++
 rtl/uart_framer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART framer: escape byte, FSM state types and
// the RX FIFO entry layout.
package uart_pkg;

    // Escape byte: it prefixes a command on the wire and is doubled for literal data.
    localparam logic [7:0] ESC_BYTE = 8'h1B;

    typedef enum logic {
        RX_IDLE,
        RX_ESC
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ESC,
        TX_BYTE
    } tx_state_e;

    // Each RX FIFO entry is a byte plus a flag that marks it as a command.
    typedef struct packed {
        logic       cmd;
        logic [7:0] data;
    } rx_entry_t;

    localparam int unsigned RX_ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/uart_fwft_fifo.sv
// First-word fall-through FIFO. The head entry is presented combinationally
// and reads as zero while the FIFO is empty. A push into a full FIFO succeeds
// only when a pop happens in the same cycle.
module uart_fwft_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are qualified by the occupancy count, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_framer.sv
// Byte-stuffing framer between a byte UART and a TAP-side interface.
// RX: ESC x decodes as command x, ESC ESC as literal ESC data, anything else
// as plain data; decoded entries queue in a FWFT FIFO.
// TX: data bytes go out as-is (ESC doubled); commands go out as ESC, cmd.
module uart_framer
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic       RX_VALID_I,
    input  logic [7:0] RX_DATA_I,
    input  logic       TX_BUSY_I,
    output logic       TX_START_O,
    output logic [7:0] TX_DATA_O,
    input  logic       READ_I,
    output logic [7:0] DATA_REC_O,
    output logic       RX_EMPTY_O,
    output logic       CMD_REC_O,
    output logic       TX_READY_O,
    input  logic       WRITE_I,
    input  logic [7:0] DATA_SEND_I,
    input  logic       SEND_COMMAND_I,
    input  logic [7:0] COMMAND_I,
    output logic       RX_OVERFLOW_O
);

    // ---------------- RX path ----------------
    rx_state_e rx_state_q;
    logic      rx_push;
    rx_entry_t rx_entry;
    rx_entry_t head;
    logic      fifo_full, fifo_empty;
    logic      overflow_q;

    // Escape decode: decides whether the incoming byte produces a FIFO entry.
    always_comb begin
        rx_push  = 1'b0;
        rx_entry = '0;
        if (RX_VALID_I) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (RX_DATA_I != ESC_BYTE) begin
                        rx_push  = 1'b1;
                        rx_entry = '{cmd: 1'b0, data: RX_DATA_I};
                    end
                end
                RX_ESC: begin
                    rx_push  = 1'b1;
                    rx_entry = '{cmd: (RX_DATA_I != ESC_BYTE), data: RX_DATA_I};
                end
                default: ;
            endcase
        end
    end

    // RX decoder state: remembers a pending escape prefix.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            rx_state_q <= RX_IDLE;
        end else if (RX_VALID_I) begin
            if (rx_state_q == RX_IDLE && RX_DATA_I == ESC_BYTE) rx_state_q <= RX_ESC;
            else                                                rx_state_q <= RX_IDLE;
        end
    end

    uart_fwft_fifo #(
        .WIDTH (RX_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i   (CLK_I),
        .rst_ni  (RST_NI),
        .push_i  (rx_push),
        .data_i  (rx_entry),
        .pop_i   (READ_I),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    // Sticky overflow: an entry was offered while full with no same-cycle pop.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) overflow_q <= 1'b0;
        else if (rx_push && fifo_full && !READ_I) overflow_q <= 1'b1;
    end

    assign DATA_REC_O    = head.data;
    assign CMD_REC_O     = head.cmd;
    assign RX_EMPTY_O    = fifo_empty;
    assign RX_OVERFLOW_O = overflow_q;

    // ---------------- TX path ----------------
    tx_state_e  tx_state_q;
    logic       pend_q;
    logic [7:0] pend_cmd_q;
    logic [7:0] byte_q;
    logic       start_q;
    logic [7:0] tx_data_q;
    logic       can_issue;

    assign TX_READY_O = (tx_state_q == TX_IDLE) && !pend_q && !TX_BUSY_I;
    assign can_issue  = !TX_BUSY_I && !start_q;
    assign TX_START_O = start_q;
    assign TX_DATA_O  = tx_data_q;

    // TX sequencer: dispatches commands/data and issues one start pulse per wire byte.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            tx_state_q <= TX_IDLE;
            pend_q     <= 1'b0;
            pend_cmd_q <= '0;
            byte_q     <= '0;
            start_q    <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            start_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (pend_q) begin
                        // Pending is released once the command is copied into byte_q,
                        // so a pulse arriving mid-sequence queues a fresh command.
                        pend_q     <= 1'b0;
                        byte_q     <= pend_cmd_q;
                        tx_state_q <= TX_ESC;
                    end else if (WRITE_I && TX_READY_O) begin
                        byte_q     <= DATA_SEND_I;
                        tx_state_q <= (DATA_SEND_I == ESC_BYTE) ? TX_ESC : TX_BYTE;
                    end
                end
                TX_ESC: begin
                    if (can_issue) begin
                        start_q    <= 1'b1;
                        tx_data_q  <= ESC_BYTE;
                        tx_state_q <= TX_BYTE;
                    end
                end
                TX_BYTE: begin
                    if (can_issue) begin
                        start_q    <= 1'b1;
                        tx_data_q  <= byte_q;
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
            if (SEND_COMMAND_I) begin
                pend_q     <= 1'b1;
                pend_cmd_q <= COMMAND_I;
            end
        end
    end

endmodule
